// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock: shadow scoreboard of EX/MEM/WB writers, ID allow/fire
// handshake, taken-branch flush/cancel sequencing and a saturating stall counter.
module id_hazard_ctrl #(
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic             id_we,
  input  logic [4:0]       id_dest,
  input  logic             id_is_load,
  input  logic             id_br_taken,
  input  logic             pipe_hold,
  output logic             id_ready,
  output logic             id_fire,
  output logic             id_drop,
  output logic             if_flush,
  output logic [2:0]       sb_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  // Entry index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]       r_e_valid;
  logic [2:0][4:0]  r_e_dest;
  logic [2:0]       r_e_load;
  logic             r_cancel;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [2:0] w_m1;
  logic [2:0] w_m2;
  logic       w_hazard;
  logic       w_ready;
  logic       w_fire;
  logic       w_flush;
  logic       w_rec;

  function automatic logic f_match(input logic used, input logic [4:0] src,
                                   input logic vld, input logic [4:0] dest);
    return used && (src != '0) && vld && (dest == src);
  endfunction

  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    w_m1[0] = f_match(id_rs1_used, id_rs1, r_e_valid[0], r_e_dest[0]);
    w_m1[1] = f_match(id_rs1_used, id_rs1, r_e_valid[1], r_e_dest[1]);
    w_m1[2] = f_match(id_rs1_used, id_rs1, r_e_valid[2], r_e_dest[2]);
    w_m2[0] = f_match(id_rs2_used, id_rs2, r_e_valid[0], r_e_dest[0]);
    w_m2[1] = f_match(id_rs2_used, id_rs2, r_e_valid[1], r_e_dest[1]);
    w_m2[2] = f_match(id_rs2_used, id_rs2, r_e_valid[2], r_e_dest[2]);
    // With forwarding only a load still in EX cannot supply its result in time.
    if (FWD_EN != 0) begin
      w_hazard = (w_m1[0] || w_m2[0]) && r_e_load[0];
    end else begin
      w_hazard = |(w_m1 | w_m2);
    end
  end

  assign w_ready = !pipe_hold && !w_hazard && !r_cancel;
  assign w_fire  = id_valid && w_ready;
  assign w_flush = w_fire && id_br_taken;
  assign w_rec   = w_fire && id_we && (id_dest != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_valid   <= '0;
      r_e_dest    <= '0;
      r_e_load    <= '0;
      r_cancel    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!pipe_hold) begin
        r_e_valid   <= {r_e_valid[1:0], w_rec};
        r_e_dest    <= {r_e_dest[1:0], id_dest};
        r_e_load    <= {r_e_load[1:0], id_is_load && w_rec};
      end
      r_cancel <= w_flush;
      if (id_valid && !w_ready && !r_cancel && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign id_ready  = w_ready;
  assign id_fire   = w_fire;
  assign id_drop   = r_cancel && id_valid;
  assign if_flush  = w_flush;
  assign sb_valid  = r_e_valid;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three instances (no forwarding, forwarding, 2-bit
// counter) checked by a directed vector table, hand sequences and a random run.
module tb_id_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load;
  logic       id_br_taken, pipe_hold;
  logic [4:0] id_rs1, id_rs2, id_dest;

  logic [2:0]  o_ready, o_fire, o_drop, o_flush;
  logic [2:0]  sb0, sb1, sb2;
  logic [31:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  id_hazard_ctrl #(.FWD_EN(0), .CNT_W(32)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_br_taken(id_br_taken), .pipe_hold(pipe_hold),
    .id_ready(o_ready[0]), .id_fire(o_fire[0]), .id_drop(o_drop[0]), .if_flush(o_flush[0]),
    .sb_valid(sb0), .stall_cnt(cnt0));

  id_hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_br_taken(id_br_taken), .pipe_hold(pipe_hold),
    .id_ready(o_ready[1]), .id_fire(o_fire[1]), .id_drop(o_drop[1]), .if_flush(o_flush[1]),
    .sb_valid(sb1), .stall_cnt(cnt1));

  id_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_dest(id_dest),
    .id_is_load(id_is_load), .id_br_taken(id_br_taken), .pipe_hold(pipe_hold),
    .id_ready(o_ready[2]), .id_fire(o_fire[2]), .id_drop(o_drop[2]), .if_flush(o_flush[2]),
    .sb_valid(sb2), .stall_cnt(cnt2));

  typedef struct {
    bit rst, hold, valid;
    bit [4:0] rs1; bit u1;
    bit [4:0] rs2; bit u2;
    bit we; bit [4:0] dest; bit ld; bit br;
  } stim_t;

  typedef struct {
    stim_t s;
    bit ready, fire, drop, flush;
    bit [2:0] sb;
    int unsigned cnt;
  } vec_t;

  typedef struct {
    int inst;
    bit [4:0] dest;
    bit ld;
    int age;
  } wr_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: list of in-flight writers tagged with instance and age.
  wr_t inflight[$];
  bit m_cancel[3];
  longint unsigned m_cnt[3];
  longint unsigned m_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};
  int m_fwd[3] = '{0, 1, 0};

  function automatic stim_t st(bit rst, bit hold, bit valid, int rs1, bit u1, int rs2, bit u2,
                               bit we, int dest, bit ld, bit br);
    stim_t s;
    s.rst = rst; s.hold = hold; s.valid = valid;
    s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
    s.we = we; s.dest = 5'(dest); s.ld = ld; s.br = br;
    return s;
  endfunction

  function automatic vec_t mkv(stim_t s, bit r, bit f, bit d, bit fl, bit [2:0] sb, int unsigned c);
    vec_t v;
    v.s = s; v.ready = r; v.fire = f; v.drop = d; v.flush = fl; v.sb = sb; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hit(bit used, bit [4:0] src, bit [4:0] d);
    return used && (src != 0) && (d == src);
  endfunction

  function automatic bit m_hazard(int m, stim_t s);
    foreach (inflight[k]) begin
      if (inflight[k].inst == m &&
          (hit(s.u1, s.rs1, inflight[k].dest) || hit(s.u2, s.rs2, inflight[k].dest))) begin
        if (m_fwd[m] == 0 || (inflight[k].age == 0 && inflight[k].ld)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_ready(int m, stim_t s);
    return !s.hold && !m_hazard(m, s) && !m_cancel[m];
  endfunction

  function automatic bit [2:0] m_sb(int m);
    bit [2:0] v = '0;
    foreach (inflight[k]) if (inflight[k].inst == m) v[inflight[k].age] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] dut_cnt(int m);
    case (m)
      0: return {32'b0, cnt0};
      1: return {32'b0, cnt1};
      default: return {62'b0, cnt2};
    endcase
  endfunction

  function automatic logic [2:0] dut_sb(int m);
    case (m)
      0: return sb0;
      1: return sb1;
      default: return sb2;
    endcase
  endfunction

  task automatic model_step(stim_t s);
    bit rdy[3];
    wr_t nq[$];
    for (int m = 0; m < 3; m++) rdy[m] = m_ready(m, s);
    foreach (inflight[k]) begin
      wr_t e = inflight[k];
      if (s.rst) continue;
      if (!s.hold) e.age++;
      if (e.age <= 2) nq.push_back(e);
    end
    if (!s.rst && !s.hold) begin
      for (int m = 0; m < 3; m++) begin
        if (s.valid && rdy[m] && s.we && s.dest != 0) begin
          wr_t e;
          e.inst = m; e.dest = s.dest; e.ld = s.ld; e.age = 0;
          nq.push_back(e);
        end
      end
    end
    inflight = nq;
    for (int m = 0; m < 3; m++) begin
      if (s.rst) begin
        m_cancel[m] = 1'b0;
        m_cnt[m] = 0;
      end else begin
        if (s.valid && !rdy[m] && !m_cancel[m] && m_cnt[m] < m_max[m]) m_cnt[m]++;
        m_cancel[m] = s.valid && rdy[m] && s.br;
      end
    end
  endtask

  task automatic model_check(stim_t s);
    for (int m = 0; m < 3; m++) begin
      bit r = m_ready(m, s);
      bit f = s.valid && r;
      chk($sformatf("rnd_ready[%0d]", m), 64'(o_ready[m]), 64'(r));
      chk($sformatf("rnd_fire[%0d]", m), 64'(o_fire[m]), 64'(f));
      chk($sformatf("rnd_drop[%0d]", m), 64'(o_drop[m]), 64'(m_cancel[m] && s.valid));
      chk($sformatf("rnd_flush[%0d]", m), 64'(o_flush[m]), 64'(f && s.br));
      chk($sformatf("rnd_sb[%0d]", m), 64'(dut_sb(m)), 64'(m_sb(m)));
      chk($sformatf("rnd_cnt[%0d]", m), dut_cnt(m), m_cnt[m]);
    end
  endtask

  task automatic drive(stim_t s);
    @(negedge clk);
    reset = s.rst; pipe_hold = s.hold; id_valid = s.valid;
    id_rs1 = s.rs1; id_rs1_used = s.u1; id_rs2 = s.rs2; id_rs2_used = s.u2;
    id_we = s.we; id_dest = s.dest; id_is_load = s.ld; id_br_taken = s.br;
    #1;
  endtask

  task automatic advance(stim_t s);
    @(posedge clk);
    model_step(s);
  endtask

  task automatic step(stim_t s);
    drive(s);
    advance(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];
  stim_t s_rst, s_idle, s;

  initial begin
    s_rst  = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s_idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Expected values are for the no-forwarding instance, seen before each edge.
    tbl.push_back(mkv(st(0,0,1, 1,1, 2,1, 1,3,0,0),  1,1,0,0, 3'b000, 0));
    tbl.push_back(mkv(st(0,0,1, 5,1, 6,1, 1,4,0,0),  1,1,0,0, 3'b001, 0));
    tbl.push_back(mkv(st(0,0,1, 5,1, 6,1, 1,8,0,0),  1,1,0,0, 3'b011, 0));
    tbl.push_back(mkv(s_idle,                        1,0,0,0, 3'b111, 0));
    tbl.push_back(mkv(st(0,0,1, 1,1, 0,0, 1,5,0,0),  1,1,0,0, 3'b110, 0));
    tbl.push_back(mkv(st(0,0,1, 5,1, 0,0, 1,6,0,0),  0,0,0,0, 3'b101, 0));
    tbl.push_back(mkv(st(0,0,1, 5,1, 0,0, 1,6,0,0),  0,0,0,0, 3'b010, 1));
    tbl.push_back(mkv(st(0,0,1, 5,1, 0,0, 1,6,0,0),  0,0,0,0, 3'b100, 2));
    tbl.push_back(mkv(st(0,0,1, 5,1, 0,0, 1,6,0,0),  1,1,0,0, 3'b000, 3));
    tbl.push_back(mkv(s_idle,                        1,0,0,0, 3'b001, 3));
    tbl.push_back(mkv(st(0,0,1, 0,1, 0,0, 1,0,0,0),  1,1,0,0, 3'b010, 3));
    tbl.push_back(mkv(st(0,0,1, 1,1, 6,0, 1,9,0,0),  1,1,0,0, 3'b100, 3));
    tbl.push_back(mkv(st(0,0,1, 0,0, 0,0, 0,0,0,1),  1,1,0,1, 3'b001, 3));
    tbl.push_back(mkv(st(0,0,1, 0,0, 0,0, 1,10,0,0), 0,0,1,0, 3'b010, 3));
    tbl.push_back(mkv(st(0,0,1, 0,0, 0,0, 1,10,0,0), 1,1,0,0, 3'b100, 3));
    tbl.push_back(mkv(st(0,1,1, 10,1, 0,0, 1,11,0,0), 0,0,0,0, 3'b001, 3));
    tbl.push_back(mkv(st(0,1,1, 10,1, 0,0, 1,11,0,0), 0,0,0,0, 3'b001, 4));
    tbl.push_back(mkv(st(0,0,1, 10,1, 0,0, 1,11,0,0), 0,0,0,0, 3'b001, 5));
    tbl.push_back(mkv(st(0,0,1, 10,1, 0,0, 1,11,0,0), 0,0,0,0, 3'b010, 6));
    tbl.push_back(mkv(st(1,0,1, 10,1, 0,0, 1,11,0,0), 0,0,0,0, 3'b100, 7));
    tbl.push_back(mkv(s_idle,                        1,0,0,0, 3'b000, 0));

    step(s_rst);
    step(s_rst);

    foreach (tbl[i]) begin
      drive(tbl[i].s);
      chk($sformatf("tbl%0d_ready", i), 64'(o_ready[0]), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_fire", i),  64'(o_fire[0]),  64'(tbl[i].fire));
      chk($sformatf("tbl%0d_drop", i),  64'(o_drop[0]),  64'(tbl[i].drop));
      chk($sformatf("tbl%0d_flush", i), 64'(o_flush[0]), 64'(tbl[i].flush));
      chk($sformatf("tbl%0d_sb", i),    64'(sb0),        64'(tbl[i].sb));
      chk($sformatf("tbl%0d_cnt", i),   64'(cnt0),       64'(tbl[i].cnt));
      advance(tbl[i].s);
    end

    // Load-use with forwarding, then non-load writer, then cancel with id_valid low.
    step(s_rst);
    s = st(0,0,1, 0,0, 0,0, 1,7,1,0); drive(s);
    chk("fwd_ld_fire", 64'(o_fire[1]), 64'd1); advance(s);
    s = st(0,0,1, 7,1, 0,0, 1,8,0,0); drive(s);
    chk("fwd_loaduse_ready", 64'(o_ready[1]), 64'd0); advance(s);
    drive(s);
    chk("fwd_after_stall_fire", 64'(o_fire[1]), 64'd1);
    chk("fwd_loaduse_cnt", 64'(cnt1), 64'd1); advance(s);
    s = st(0,0,1, 0,0, 0,0, 1,7,0,0); drive(s);
    chk("fwd_alu_fire", 64'(o_fire[1]), 64'd1); advance(s);
    s = st(0,0,1, 0,0, 7,1, 0,0,0,0); drive(s);
    chk("fwd_alu_use_ready", 64'(o_ready[1]), 64'd1); advance(s);
    drive(s_idle);
    chk("fwd_alu_use_cnt", 64'(cnt1), 64'd1); advance(s_idle);
    s = st(0,0,1, 0,0, 0,0, 0,0,0,1); drive(s);
    chk("fwd_br_flush", 64'(o_flush[1]), 64'd1); advance(s);
    drive(s_idle);
    chk("fwd_cancel_ready", 64'(o_ready[1]), 64'd0);
    chk("fwd_cancel_nodrop", 64'(o_drop[1]), 64'd0); advance(s_idle);
    drive(s_idle);
    chk("fwd_cancel_cleared", 64'(o_ready[1]), 64'd1); advance(s_idle);

    // Counter saturation on the 2-bit instance.
    step(s_rst);
    s = st(0,1,1, 0,0, 0,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) step(s);
    drive(s_idle);
    chk("sat_cnt2", 64'(cnt2), 64'd3);
    chk("sat_cnt32", 64'(cnt0), 64'd5);
    advance(s_idle);

    // Random run against the reference model.
    step(s_rst);
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.hold  = ($urandom_range(0, 99) < 12);
      s.valid = ($urandom_range(0, 99) < 85);
      s.rs1   = 5'($urandom_range(0, 7));
      s.u1    = ($urandom_range(0, 99) < 70);
      s.rs2   = 5'($urandom_range(0, 7));
      s.u2    = ($urandom_range(0, 99) < 60);
      s.we    = ($urandom_range(0, 99) < 75);
      s.dest  = 5'($urandom_range(0, 7));
      s.ld    = ($urandom_range(0, 99) < 30);
      s.br    = ($urandom_range(0, 99) < 10);
      drive(s);
      model_check(s);
      advance(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
